// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master side drives operands and start; the slave side returns results and status.
interface seq_divider_if #(
    parameter int unsigned QW = 16,
    parameter int unsigned RW = 12,
    parameter int unsigned DW = QW + RW
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [RW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic [RW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: DW-bit dividend / RW-bit divisor, one quotient bit per clock.
// Define DIV_EARLY_ERR_EN to let divide-by-zero and overflow ops skip the iteration phase.
module seq_divider #(
    parameter int unsigned QW = 16,
    parameter int unsigned RW = 12,
    parameter int unsigned DW = QW + RW
) (
    input logic        clk,
    input logic        reset,
    seq_divider_if.slave bus
);

    localparam int unsigned CW = $clog2(QW);
    localparam logic [CW-1:0] LastIter = CW'(QW - 1);

`ifdef DIV_EARLY_ERR_EN
    localparam bit EarlyErr = 1'b1;
`else
    localparam bit EarlyErr = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW:0]   prem_q, prem_d;     // partial remainder P
    logic [QW-1:0] shift_q, shift_d;   // low dividend bits out, quotient bits in
    logic [RW-1:0] dsr_q, dsr_d;
    logic          err_dz_q, err_dz_d;
    logic          err_ov_q, err_ov_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [QW-1:0] quo_q, quo_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;

    logic [RW:0]   trial;
    logic [RW:0]   diff;
    logic          fits;
    logic          acc_dz;
    logic          acc_ov;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prem_d   = prem_q;
        shift_d  = shift_q;
        dsr_d    = dsr_q;
        err_dz_d = err_dz_q;
        err_ov_d = err_ov_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        ov_d     = ov_q;

        trial  = {prem_q[RW-1:0], shift_q[QW-1]};
        diff   = trial - {1'b0, dsr_q};
        fits   = (trial >= {1'b0, dsr_q});
        acc_dz = (bus.divisor == '0);
        // Quotient fits in QW bits only if the top RW dividend bits are below the divisor.
        acc_ov = !acc_dz && (bus.dividend[DW-1:QW] >= bus.divisor);

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    shift_d  = bus.dividend[QW-1:0];
                    prem_d   = {1'b0, bus.dividend[DW-1:QW]};
                    dsr_d    = bus.divisor;
                    cnt_d    = '0;
                    err_dz_d = acc_dz;
                    err_ov_d = acc_ov;
                    busy_d   = 1'b1;
                    dz_d     = 1'b0;
                    ov_d     = 1'b0;
                    state_d  = (EarlyErr && (acc_dz || acc_ov)) ? StDone : StRun;
                end
            end
            StRun: begin
                prem_d  = fits ? diff : trial;
                shift_d = {shift_q[QW-2:0], fits};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = err_dz_q;
                ov_d    = err_ov_q;
                if (err_dz_q || err_ov_q) begin
                    quo_d = '1;
                    rem_d = '0;
                end else begin
                    quo_d = shift_q;
                    rem_d = prem_q[RW-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prem_q   <= '0;
            shift_q  <= '0;
            dsr_q    <= '0;
            err_dz_q <= 1'b0;
            err_ov_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prem_q   <= prem_d;
            shift_q  <= shift_d;
            dsr_q    <= dsr_d;
            err_dz_q <= err_dz_d;
            err_ov_q <= err_ov_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
            ov_q     <= ov_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;

endmodule
